dvp_source: RTL

- Transmit side of the camera parallel pixel bus (vsync/href/p_data, one byte per p_clock).
- Drives a capture-style receiver from an internal frame source: test pattern generator, frame-buffer readback or loopback bench.
- Accepts 24-bit RGB888 pixels over a valid/ready handshake and serialises each pixel as two RGB565 bytes.
- Generates programmable frame timing: vsync pulse, front porch, active lines with href, horizontal blanking, back porch.

---
 rtl/dvp_source.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/dvp_source.sv
// dvp_source: transmit side of a camera-style parallel pixel bus.
// Takes RGB888 pixels over a valid/ready handshake. Each pixel goes out as
// two RGB565 bytes on p_data while href is high. The block also produces the
// frame timing: vsync, front porch, active lines with horizontal blanking,
// and back porch.
//
// Ports:
//   p_clock      pixel/byte clock, everything on the rising edge
//   rst          synchronous, active-high reset
//   enable       frame generation request, sampled at frame boundaries
//   pix_in       RGB888 pixel {R[23:16], G[15:8], B[7:0]}
//   pix_valid    pix_in holds a pixel
//   pix_ready    holding register is empty (registered)
//   vsync        frame sync, active high
//   href         line valid, active high
//   p_data       byte lane, 0x00 whenever href is low
//   frame_start  one-cycle pulse on the first clock of a frame
//   frame_done   one-cycle pulse on the last clock of a frame
//   underrun     one-cycle pulse when a pixel slot finds no pixel
module dvp_source #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_FRONT     = 2,
  parameter int V_BACK      = 2
) (
  input  logic        p_clock,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        underrun
);

  localparam int LINE_CLKS   = 2 * H_ACTIVE + H_BLANK;
  localparam int VSYNC_CLKS  = VSYNC_LINES * LINE_CLKS;
  localparam int VFRONT_CLKS = V_FRONT * LINE_CLKS;
  localparam int ACT_CLKS    = 2 * H_ACTIVE;
  localparam int VBACK_CLKS  = V_BACK * LINE_CLKS;

  localparam int MAX_A    = (VSYNC_CLKS > VFRONT_CLKS) ? VSYNC_CLKS : VFRONT_CLKS;
  localparam int MAX_B    = (ACT_CLKS > H_BLANK) ? ACT_CLKS : H_BLANK;
  localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CLKS = (MAX_C > VBACK_CLKS) ? MAX_C : VBACK_CLKS;
  localparam int CW       = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
  localparam int LW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VFRONT,
    ACTIVE,
    HBLANK,
    VBACK
  } state_t;

  // Successor chain with zero-length phases folded out. IDLE here means
  // "the frame is over"; the next-state logic then decides between a new
  // frame and going idle.
  localparam state_t LINE_START  = (ACT_CLKS > 0) ? ACTIVE : HBLANK;
  localparam state_t POST_ACTIVE = (VBACK_CLKS > 0) ? VBACK : IDLE;
  localparam state_t PRE_ACTIVE  = (V_ACTIVE > 0) ? LINE_START : POST_ACTIVE;
  localparam state_t POST_VSYNC  = (VFRONT_CLKS > 0) ? VFRONT : PRE_ACTIVE;
  localparam state_t FRAME_FIRST = (VSYNC_CLKS > 0) ? VSYNC : POST_VSYNC;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [LW-1:0]   line_cnt, line_next;
  logic            starting;
  logic            last, line_last;
  logic            frame_end, new_frame;
  logic [15:0]     hold;
  logic [7:0]      low_byte;
  logic            even_slot, odd_slot;

  // Only the bits that survive the RGB565 reduction are stored.
  logic unused_pix_bits;
  assign unused_pix_bits = ^{pix_in[18:16], pix_in[9:8], pix_in[2:0]};

  // Terminal count of the current phase.
  always_comb begin
    last = 1'b0;
    case (state)
      VSYNC:  last = (cnt == CW'(VSYNC_CLKS  > 0 ? VSYNC_CLKS  - 1 : 0));
      VFRONT: last = (cnt == CW'(VFRONT_CLKS > 0 ? VFRONT_CLKS - 1 : 0));
      ACTIVE: last = (cnt == CW'(ACT_CLKS    > 0 ? ACT_CLKS    - 1 : 0));
      HBLANK: last = (cnt == CW'(H_BLANK     > 0 ? H_BLANK     - 1 : 0));
      VBACK:  last = (cnt == CW'(VBACK_CLKS  > 0 ? VBACK_CLKS  - 1 : 0));
      default: last = 1'b0;
    endcase
  end

  assign line_last = (line_cnt == LW'(V_ACTIVE > 0 ? V_ACTIVE - 1 : 0));

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    line_next  = line_cnt;
    frame_end  = 1'b0;
    new_frame  = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (enable) begin
          state_next = FRAME_FIRST;
          new_frame  = 1'b1;
        end
      end
      VSYNC: if (last) begin
        cnt_next   = '0;
        state_next = POST_VSYNC;
      end
      VFRONT: if (last) begin
        cnt_next   = '0;
        state_next = PRE_ACTIVE;
      end
      ACTIVE: if (last) begin
        cnt_next = '0;
        if (H_BLANK > 0) begin
          state_next = HBLANK;
        end else if (!line_last) begin
          state_next = ACTIVE;
          line_next  = line_cnt + 1'b1;
        end else begin
          state_next = POST_ACTIVE;
        end
      end
      HBLANK: if (last) begin
        cnt_next = '0;
        if (!line_last) begin
          state_next = LINE_START;
          line_next  = line_cnt + 1'b1;
        end else begin
          state_next = POST_ACTIVE;
        end
      end
      VBACK: if (last) begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // Leaving the last phase of a frame: flag the end and chain straight
    // into the next frame when enable is still high.
    if (state != IDLE && last && state_next == IDLE) begin
      frame_end = 1'b1;
      if (enable) begin
        state_next = FRAME_FIRST;
        new_frame  = 1'b1;
      end
    end
    if (new_frame) begin
      line_next = '0;
    end
  end

  always_ff @(posedge p_clock) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      line_cnt <= '0;
      starting <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      line_cnt <= line_next;
      starting <= new_frame;
    end
  end

  // Bus outputs trail the phase state by one register stage, so each pulse
  // lines up with the clock it describes on the wire.
  always_ff @(posedge p_clock) begin
    if (rst) begin
      vsync       <= 1'b0;
      href        <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      vsync       <= (state == VSYNC);
      href        <= (state == ACTIVE);
      frame_start <= starting;
      frame_done  <= frame_end;
    end
  end

  assign even_slot = (state == ACTIVE) && !cnt[0];
  assign odd_slot  = (state == ACTIVE) &&  cnt[0];

  // Single-entry holding register. pix_ready is the registered empty flag.
  // A consume needs it low and an accept needs it high, so the two never
  // collide. The slot is refilled during the odd byte of the previous pixel.
  always_ff @(posedge p_clock) begin
    if (rst) begin
      hold      <= '0;
      low_byte  <= '0;
      pix_ready <= 1'b1;
      p_data    <= 8'h00;
      underrun  <= 1'b0;
    end else begin
      p_data   <= 8'h00;
      underrun <= 1'b0;
      if (even_slot) begin
        if (!pix_ready) begin
          p_data    <= hold[15:8];
          low_byte  <= hold[7:0];
          pix_ready <= 1'b1;
        end else begin
          low_byte <= 8'h00;
          underrun <= 1'b1;
        end
      end else if (odd_slot) begin
        p_data <= low_byte;
      end
      if (pix_valid && pix_ready) begin
        hold      <= {pix_in[23:19], pix_in[15:10], pix_in[7:3]};
        pix_ready <= 1'b0;
      end
    end
  end

endmodule
